task_15_pwm_driver: RTL and testbench

- Downstream stage of the task_15 PID loop. Consumes the controller output `y_port` (sfix16_En14) plus its valid strobe.
- Saturates the value and converts it to an unsigned duty count.
- Drives a complementary PWM pair from a free-running carrier counter. Duty is double-buffered so it only changes at a carrier-period boundary (glitch-free).

---
 rtl/task_15_pwm_pkg.sv | 24 ++
 rtl/task_15_pwm_deadband.sv | 47 ++++
 rtl/task_15_pwm_driver.sv | 132 +++++++++++++
 tb/tb_task_15_pwm_driver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/task_15_pwm_pkg.sv
// ============================================================================
// Module  : task_15_pwm_pkg
// Purpose : Shared types and constants for the task_15 PWM driver.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package task_15_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    typedef logic signed [15:0] fix16_en14_t;

    localparam fix16_en14_t c_SAT_MAX_DEF = 16'sh3FFF;
    localparam fix16_en14_t c_SAT_MIN_DEF = 16'shC000;
    localparam int          c_DIFF_W      = 17;

endpackage

`default_nettype wire

// File: rtl/task_15_pwm_deadband.sv
// ============================================================================
// Module  : task_15_pwm_deadband
// Purpose : Delays rising edges of one gate request by DEADTIME clocks;
//           falling edges pass straight through.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module task_15_pwm_deadband #(
    parameter int DEADTIME = 4
) (
    input  logic clk,
    input  logic reset_x_n,
    input  logic i_en,
    input  logic i_req,
    output logic o_gate
);

    localparam int              c_W      = $clog2(DEADTIME + 1);
    localparam logic [c_W-1:0]  c_RELOAD = c_W'(DEADTIME - 1);

    logic           r_prev;
    logic [c_W-1:0] r_cnt;
    logic           w_rise;

    assign w_rise = i_req & ~r_prev;

    always_ff @(posedge clk or negedge reset_x_n) begin
        if (!reset_x_n) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else if (i_en) begin
            r_prev <= i_req;
            if (w_rise) begin
                r_cnt <= c_RELOAD;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_W'(1);
            end
        end
    end

    // Gate opens only once the request has been held through the full delay.
    assign o_gate = i_req & r_prev & (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/task_15_pwm_driver.sv
// ============================================================================
// Module  : task_15_pwm_driver
// Purpose : Saturating duty mapper and double-buffered complementary PWM.
//           Optional dead band enabled by TASK_15_PWM_DEADTIME_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module task_15_pwm_driver
    import task_15_pwm_pkg::*;
#(
    parameter int          CNT_W    = 10,
    parameter fix16_en14_t SAT_MAX  = c_SAT_MAX_DEF,
    parameter fix16_en14_t SAT_MIN  = c_SAT_MIN_DEF,
    parameter int          DEADTIME = 4
) (
    input  logic             clk,
    input  logic             reset_x_n,
    input  logic             enb,
    input  logic [15:0]      y_in,
    input  logic             y_valid,
    input  logic             kill,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             period_start,
    output logic [CNT_W-1:0] duty_o,
    output logic [7:0]       sat_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam int               c_SHIFT   = 16 - 1 - CNT_W;

    state_t                     r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           r_duty_pend;
    logic [CNT_W-1:0]           r_duty_act;
    logic                       r_req_h;
    logic                       r_req_l;
    logic                       r_period_start;
    logic [7:0]                 r_sat_cnt;

    fix16_en14_t                w_y;
    fix16_en14_t                w_sat;
    logic                       w_clip_hi;
    logic                       w_clip_lo;
    logic signed [c_DIFF_W-1:0] w_diff;
    logic [CNT_W-1:0]           w_duty_new;
    logic                       w_wrap;
    logic                       w_cmp;

    assign w_y        = y_in;
    assign w_clip_hi  = w_y > SAT_MAX;
    assign w_clip_lo  = w_y < SAT_MIN;
    assign w_sat      = w_clip_hi ? SAT_MAX : (w_clip_lo ? SAT_MIN : w_y);
    assign w_diff     = c_DIFF_W'(w_sat) - c_DIFF_W'(SAT_MIN);
    assign w_duty_new = CNT_W'(w_diff >>> c_SHIFT);
    assign w_wrap     = (r_cnt == c_CNT_MAX);
    assign w_cmp      = (r_cnt < r_duty_act);

    always_ff @(posedge clk or negedge reset_x_n) begin
        if (!reset_x_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_duty_pend    <= '0;
            r_duty_act     <= '0;
            r_req_h        <= 1'b0;
            r_req_l        <= 1'b0;
            r_period_start <= 1'b0;
            r_sat_cnt      <= '0;
        end else if (enb) begin
            r_cnt          <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            r_period_start <= w_wrap;
            if (kill) begin
                r_state     <= IDLE;
                r_req_h     <= 1'b0;
                r_req_l     <= 1'b0;
                r_duty_pend <= '0;
                r_duty_act  <= '0;
            end else begin
                r_req_h <= (r_state == RUN) &&  w_cmp;
                r_req_l <= (r_state == RUN) && !w_cmp;
                // Shadow load takes the pending value from before this edge.
                if (w_wrap) begin
                    r_duty_act <= r_duty_pend;
                end
                if (y_valid) begin
                    r_duty_pend <= w_duty_new;
                    if ((w_clip_hi || w_clip_lo) && (r_sat_cnt != 8'hFF)) begin
                        r_sat_cnt <= r_sat_cnt + 8'd1;
                    end
                end
                case (r_state)
                    IDLE:    if (y_valid) r_state <= ARMED;
                    ARMED:   if (w_wrap)  r_state <= RUN;
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    if (DEADTIME < 1) begin : g_deadtime_chk
        $error("DEADTIME must be at least 1");
    end

`ifdef TASK_15_PWM_DEADTIME_EN
    task_15_pwm_deadband #(.DEADTIME(DEADTIME)) u_db_h (
        .clk       (clk),
        .reset_x_n (reset_x_n),
        .i_en      (enb),
        .i_req     (r_req_h),
        .o_gate    (pwm_h)
    );

    task_15_pwm_deadband #(.DEADTIME(DEADTIME)) u_db_l (
        .clk       (clk),
        .reset_x_n (reset_x_n),
        .i_en      (enb),
        .i_req     (r_req_l),
        .o_gate    (pwm_l)
    );
`else
    assign pwm_h = r_req_h;
    assign pwm_l = r_req_l;
`endif

    assign period_start = r_period_start;
    assign duty_o       = r_duty_act;
    assign sat_cnt      = r_sat_cnt;

endmodule

`default_nettype wire

// File: tb/tb_task_15_pwm_driver.sv
// ============================================================================
// Module  : tb_task_15_pwm_driver
// Purpose : Scoreboard bench for task_15_pwm_driver against a cycle-level
//           reference model of the carrier, duty buffering and gating rules.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_task_15_pwm_driver;

    logic        clk = 1'b0;
    logic        reset_x_n;
    logic        enb;
    logic [15:0] y_in;
    logic        y_valid;
    logic        kill;
    logic        pwm_h;
    logic        pwm_l;
    logic        period_start;
    logic [9:0]  duty_o;
    logic [7:0]  sat_cnt;

    always #5 clk = ~clk;

    task_15_pwm_driver dut (
        .clk          (clk),
        .reset_x_n    (reset_x_n),
        .enb          (enb),
        .y_in         (y_in),
        .y_valid      (y_valid),
        .kill         (kill),
        .pwm_h        (pwm_h),
        .pwm_l        (pwm_l),
        .period_start (period_start),
        .duty_o       (duty_o),
        .sat_cnt      (sat_cnt)
    );

    typedef struct {
        bit h;
        bit l;
        bit ps;
        int duty;
        int sat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: 0 = idle, 1 = armed, 2 = running.
    int m_cnt, m_state, m_pend, m_act, m_sat;
    bit m_h, m_l, m_ps;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_cnt = 0; m_state = 0; m_pend = 0; m_act = 0; m_sat = 0;
        m_h = 0; m_l = 0; m_ps = 0;
    endfunction

    function automatic void model_step(bit en, bit yv, int y, bit k);
        bit wrap;
        int ns;
        int s;
        if (!en) return;
        wrap = (m_cnt == 1023);
        ns   = m_state;
        m_ps = wrap;
        if (k) begin
            m_h = 0; m_l = 0; ns = 0; m_pend = 0; m_act = 0;
        end else begin
            m_h = (m_state == 2) && (m_cnt <  m_act);
            m_l = (m_state == 2) && (m_cnt >= m_act);
            if (wrap) m_act = m_pend;
            if (yv) begin
                s = y;
                if (s > 16383 || s < -16384) begin
                    s = (s > 16383) ? 16383 : -16384;
                    if (m_sat < 255) m_sat++;
                end
                m_pend = (s + 16384) / 32;
            end
            if (m_state == 0 && yv)        ns = 1;
            else if (m_state == 1 && wrap) ns = 2;
        end
        m_state = ns;
        m_cnt   = (m_cnt + 1) % 1024;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.h = m_h; e.l = m_l; e.ps = m_ps; e.duty = m_act; e.sat = m_sat;
        q.push_back(e);
    endfunction

    // Called at posedge+1; drives inputs for the next edge, then models it.
    task automatic step(bit en, bit yv, logic [15:0] y, bit k);
        enb = en; y_valid = yv; y_in = y; kill = k;
        @(posedge clk);
        if (reset_x_n) model_step(en, yv, int'($signed(y)), k);
        else           model_reset();
        push_exp();
        #1;
    endtask

    task automatic run(int n);
        repeat (n) step(1'b1, 1'b0, 16'($urandom()), 1'b0);
    endtask

    task automatic wait_cnt(int c);
        int guard = 0;
        while (m_cnt != c && guard < 2048) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            guard++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
`ifndef TASK_15_PWM_DEADTIME_EN
            chk("pwm_h", int'(pwm_h), int'(e.h));
            chk("pwm_l", int'(pwm_l), int'(e.l));
`endif
            chk("period_start", int'(period_start), int'(e.ps));
            chk("duty_o", int'(duty_o), e.duty);
            chk("sat_cnt", int'(sat_cnt), e.sat);
            chk("gate_overlap", int'(pwm_h & pwm_l), 0);
        end
    end

    initial begin
        logic [15:0] ry;
        reset_x_n = 1'b0; enb = 1'b0; y_in = '0; y_valid = 1'b0; kill = 1'b0;
        model_reset();
        #1;
        repeat (3) step(1'b0, 1'b0, 16'h0, 1'b0);
        reset_x_n = 1'b1;

        // Mid-scale sample, then two full periods.
        step(1'b1, 1'b1, 16'h0000, 1'b0);
        run(2100);

        // Positive then negative clipping.
        step(1'b1, 1'b1, 16'h7000, 1'b0);
        run(1100);
        step(1'b1, 1'b1, 16'h8000, 1'b0);
        run(1100);

        // New sample coinciding with the wrap edge.
        step(1'b1, 1'b1, 16'h0000, 1'b0);
        wait_cnt(1023);
        step(1'b1, 1'b1, 16'h2000, 1'b0);
        run(2100);

        // Kill mid-period, then re-arm.
        wait_cnt(300);
        step(1'b1, 1'b0, 16'h0, 1'b1);
        run(50);
        step(1'b1, 1'b1, 16'h1000, 1'b0);
        run(2100);

        // Clock enable held low for 100 clocks mid-period.
        wait_cnt(200);
        repeat (100) step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom()), 1'b0);
        run(1100);

        // Duty at full scale for the one-clock low pulse.
        step(1'b1, 1'b1, 16'h3FFF, 1'b0);
        run(2100);

        // Randomized traffic.
        for (int i = 0; i < 6000; i++) begin
            ry = ($urandom_range(0, 1) == 0) ? 16'($urandom()) : 16'($urandom_range(16'hC000, 16'hFFFF) ^ 16'h8000);
            step(1'($urandom_range(0, 19) != 0),
                 1'($urandom_range(0, 199) == 0),
                 ry,
                 1'($urandom_range(0, 2999) == 0));
        end

        // Asynchronous reset mid-period.
        step(1'b1, 1'b1, 16'h0000, 1'b0);
        wait_cnt(1023);
        run(500);
        #1;
        reset_x_n = 1'b0;
        #1;
        chk("async_rst_pwm_h", int'(pwm_h), 0);
        chk("async_rst_pwm_l", int'(pwm_l), 0);
        chk("async_rst_duty", int'(duty_o), 0);
        chk("async_rst_sat", int'(sat_cnt), 0);
        chk("async_rst_ps", int'(period_start), 0);
        q.delete();
        model_reset();
        @(posedge clk);
        #1;
        repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0);
        reset_x_n = 1'b1;
        step(1'b1, 1'b1, 16'hE000, 1'b0);
        run(2100);

        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
